// File: rtl/regfile_multiport.sv
// Multi-port integer register file with a sequential clear sweep and a debug read port.
// Optional write-to-read forwarding on the rs ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRP   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_req,
    output logic                busy,
    input  logic                reg_write,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     wd,
    output logic                wr_dropped,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_val,
    input  logic [AW-1:0]       dbg_sel,
    output logic [XLEN-1:0]     dbg_val
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t          state_q;
    logic [AW-1:0]   clr_idx_q;
    logic            busy_q;
    logic            wr_dropped_q;
    logic [XLEN-1:0] mem_q [NREGS];

    logic            wr_en_d;
    logic            wr_drop_d;

    assign wr_en_d   = (state_q == ST_READY) && reg_write && (rd != '0);
    assign wr_drop_d = (state_q == ST_CLEAR) && reg_write && (rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_idx_q    <= AW'(1);
            busy_q       <= 1'b1;
            wr_dropped_q <= 1'b0;
        end else begin
            wr_dropped_q <= wr_drop_d;
            case (state_q)
                ST_CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end else begin
                        clr_idx_q <= clr_idx_q + AW'(1);
                    end
                end
                ST_READY: begin
                    // clear_req while busy never reaches here, so it cannot extend a sweep
                    if (clear_req) begin
                        state_q   <= ST_CLEAR;
                        busy_q    <= 1'b1;
                        clr_idx_q <= AW'(1);
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; entry 0 is never written and is masked on every read.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_en_d) begin
            mem_q[rd] <= wd;
        end
    end

    always_comb begin
        rs_val = '0;
        for (int k = 0; k < NRP; k++) begin
            if (!busy_q && (rs_addr[k*AW +: AW] != '0)) begin
                rs_val[k*XLEN +: XLEN] = mem_q[rs_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (wr_en_d && (rs_addr[k*AW +: AW] == rd)) begin
                    rs_val[k*XLEN +: XLEN] = wd;
                end
`endif
            end
        end
    end

    always_comb begin
        dbg_val = '0;
        if (!busy_q && (dbg_sel != '0)) begin
            dbg_val = mem_q[dbg_sel];
        end
    end

    assign busy       = busy_q;
    assign wr_dropped = wr_dropped_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport (XLEN=32, NREGS=32, NRP=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1ns after it.
module tb_regfile_multiport;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRP   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst_n;
  logic                clear_req;
  logic                busy;
  logic                reg_write;
  logic [AW-1:0]       rd;
  logic [XLEN-1:0]     wd;
  logic                wr_dropped;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_val;
  logic [AW-1:0]       dbg_sel;
  logic [XLEN-1:0]     dbg_val;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model [NREGS];
  logic [XLEN-1:0] exp;
  logic [XLEN-1:0] got;

  regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .busy       (busy),
    .reg_write  (reg_write),
    .rd         (rd),
    .wd         (wd),
    .wr_dropped (wr_dropped),
    .rs_addr    (rs_addr),
    .rs_val     (rs_val),
    .dbg_sel    (dbg_sel),
    .dbg_val    (dbg_val)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic set_rs(input int k, input logic [AW-1:0] a);
    rs_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [XLEN-1:0] rs_port(input int k);
    return rs_val[k*XLEN +: XLEN];
  endfunction

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    @(negedge clk);
    reg_write = 1'b1;
    rd        = a;
    wd        = d;
    @(negedge clk);
    reg_write = 1'b0;
    if (a != '0) model[a] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) model[i] = '0;
  endtask

  // scenarios
  task automatic test_reset();
    int n;
    rst_n = 1'b0; clear_req = 1'b0; reg_write = 1'b0;
    rd = '0; wd = '0; rs_addr = '0; dbg_sel = '0;
    clear_model();
    repeat (3) @(negedge clk);
    set_rs(0, 5'd3); set_rs(1, 5'd17); dbg_sel = 5'd9;
    #1;
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); got = {31'b0, busy}; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_busy got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); got = {31'b0, wr_dropped}; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_wr_dropped got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); got = rs_port(0); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_rs0 got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = rs_port(1); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_rs1 got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = dbg_val; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_dbg got=%h exp=%h", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'd31);
    count_busy(n);
    exp = exp_q.pop_front(); got = n; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_busy_cycles got=%0d exp=%0d", got, exp); end
    for (int i = 0; i < NREGS; i++) begin
      set_rs(0, AW'(i)); set_rs(1, AW'(NREGS - 1 - i)); dbg_sel = AW'(i);
      exp_q.push_back(model[i]); exp_q.push_back(model[NREGS - 1 - i]); exp_q.push_back(model[i]);
      #1;
      exp = exp_q.pop_front(); got = rs_port(0); checks++;
      if (got !== exp) begin errors++; $display("FAIL init_rs0 x%0d got=%h exp=%h", i, got, exp); end
      exp = exp_q.pop_front(); got = rs_port(1); checks++;
      if (got !== exp) begin errors++; $display("FAIL init_rs1 x%0d got=%h exp=%h", NREGS-1-i, got, exp); end
      exp = exp_q.pop_front(); got = dbg_val; checks++;
      if (got !== exp) begin errors++; $display("FAIL init_dbg x%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 32'hDEADBEEF);
    set_rs(0, 5'd5); set_rs(1, 5'd5);
    exp_q.push_back(model[5]); exp_q.push_back(32'hDEADBEEF);
    #1;
    exp = exp_q.pop_front(); got = rs_port(0); checks++;
    if (got !== exp) begin errors++; $display("FAIL wr_rd_port0 got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = rs_port(1); checks++;
    if (got !== exp) begin errors++; $display("FAIL wr_rd_port1 got=%h exp=%h", got, exp); end
    @(negedge clk);
    reg_write = 1'b1; rd = 5'd0; wd = 32'h12345678;
    @(negedge clk);
    reg_write = 1'b0;
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); got = {31'b0, wr_dropped}; checks++;
    if (got !== exp) begin errors++; $display("FAIL x0_no_drop got=%h exp=%h", got, exp); end
    set_rs(0, 5'd0); dbg_sel = 5'd0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); got = rs_port(0); checks++;
    if (got !== exp) begin errors++; $display("FAIL x0_rs got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = dbg_val; checks++;
    if (got !== exp) begin errors++; $display("FAIL x0_dbg got=%h exp=%h", got, exp); end
  endtask

  task automatic test_clear_drop();
    int n;
    write_reg(5'd2, 32'h22222222);
    write_reg(5'd7, 32'h77777777);
    set_rs(0, 5'd5); set_rs(1, 5'd2);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 1) begin
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp = exp_q.pop_front(); got = rs_port(0); checks++;
        if (got !== exp) begin errors++; $display("FAIL busy_rs0 got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front(); got = rs_port(1); checks++;
        if (got !== exp) begin errors++; $display("FAIL busy_rs1 got=%h exp=%h", got, exp); end
      end
      if (n == 3) begin
        reg_write = 1'b1; rd = 5'd7; wd = 32'hA5A5A5A5;
        exp_q.push_back(32'd1);
      end
      if (n == 4) begin
        exp = exp_q.pop_front(); got = {31'b0, wr_dropped}; checks++;
        if (got !== exp) begin errors++; $display("FAIL drop_x7 got=%h exp=%h", got, exp); end
        rd = 5'd2; wd = 32'h5A5A5A5A;
        exp_q.push_back(32'd1);
      end
      if (n == 5) begin
        exp = exp_q.pop_front(); got = {31'b0, wr_dropped}; checks++;
        if (got !== exp) begin errors++; $display("FAIL drop_x2 got=%h exp=%h", got, exp); end
        reg_write = 1'b0;
        clear_req = 1'b1;
        exp_q.push_back(32'd0);
      end
      if (n == 6) begin
        clear_req = 1'b0;
        exp = exp_q.pop_front(); got = {31'b0, wr_dropped}; checks++;
        if (got !== exp) begin errors++; $display("FAIL drop_pulse_end got=%h exp=%h", got, exp); end
      end
      @(negedge clk);
    end
    clear_model();
    exp_q.push_back(32'd31);
    exp = exp_q.pop_front(); got = n; checks++;
    if (got !== exp) begin errors++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", got, exp); end
    set_rs(0, 5'd7); set_rs(1, 5'd2); dbg_sel = 5'd5;
    exp_q.push_back(model[7]); exp_q.push_back(model[2]); exp_q.push_back(model[5]);
    #1;
    exp = exp_q.pop_front(); got = rs_port(0); checks++;
    if (got !== exp) begin errors++; $display("FAIL cleared_x7 got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = rs_port(1); checks++;
    if (got !== exp) begin errors++; $display("FAIL cleared_x2 got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = dbg_val; checks++;
    if (got !== exp) begin errors++; $display("FAIL cleared_x5 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_midsweep();
    int n;
    write_reg(5'd5, 32'h55555555);
    set_rs(0, 5'd5); dbg_sel = 5'd5;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 10) begin
      n++;
      if (n < 10) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    exp_q.push_back(32'd10); exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); got = n; checks++;
    if (got !== exp) begin errors++; $display("FAIL midsweep_reach got=%0d exp=%0d", got, exp); end
    exp = exp_q.pop_front(); got = {31'b0, busy}; checks++;
    if (got !== exp) begin errors++; $display("FAIL midsweep_busy got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = rs_port(0); checks++;
    if (got !== exp) begin errors++; $display("FAIL midsweep_rs got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = dbg_val; checks++;
    if (got !== exp) begin errors++; $display("FAIL midsweep_dbg got=%h exp=%h", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'd31);
    count_busy(n);
    exp = exp_q.pop_front(); got = n; checks++;
    if (got !== exp) begin errors++; $display("FAIL midsweep_busy_cycles got=%0d exp=%0d", got, exp); end
    clear_model();
    #1;
    exp_q.push_back(model[5]);
    exp = exp_q.pop_front(); got = rs_port(0); checks++;
    if (got !== exp) begin errors++; $display("FAIL midsweep_x5 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_bypass();
    write_reg(5'd9, 32'h11111111);
    @(negedge clk);
    reg_write = 1'b1; rd = 5'd9; wd = 32'hCAFEF00D;
    set_rs(0, 5'd9); set_rs(1, 5'd9); dbg_sel = 5'd9;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'hCAFEF00D);
`else
    exp_q.push_back(model[9]); exp_q.push_back(model[9]);
`endif
    exp_q.push_back(model[9]);
    #1;
    exp = exp_q.pop_front(); got = rs_port(0); checks++;
    if (got !== exp) begin errors++; $display("FAIL same_cycle_rs0 got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = rs_port(1); checks++;
    if (got !== exp) begin errors++; $display("FAIL same_cycle_rs1 got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = dbg_val; checks++;
    if (got !== exp) begin errors++; $display("FAIL same_cycle_dbg got=%h exp=%h", got, exp); end
    @(negedge clk);
    model[9] = 32'hCAFEF00D;
    rd = 5'd0; wd = 32'hFFFFFFFF;
    set_rs(1, 5'd0);
    exp_q.push_back(model[9]); exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); got = rs_port(0); checks++;
    if (got !== exp) begin errors++; $display("FAIL after_write_x9 got=%h exp=%h", got, exp); end
    exp = exp_q.pop_front(); got = rs_port(1); checks++;
    if (got !== exp) begin errors++; $display("FAIL bypass_x0 got=%h exp=%h", got, exp); end
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    for (int i = 1; i < NREGS; i++) begin
      @(negedge clk);
      reg_write = 1'b1; rd = AW'(i); wd = i * 32'h01010101;
      model[i] = i * 32'h01010101;
    end
    @(negedge clk);
    reg_write = 1'b0;
    for (int i = 0; i < NREGS; i++) exp_q.push_back(model[i]);
    for (int i = 0; i < NREGS; i++) begin
      dbg_sel = AW'(i);
      #1;
      exp = exp_q.pop_front(); got = dbg_val; checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_dbg x%0d got=%h exp=%h", i, got, exp); end
    end
    for (int j = 0; j < 8; j++) begin
      a = AW'($urandom_range(0, NREGS - 1));
      b = AW'($urandom_range(0, NREGS - 1));
      set_rs(0, a); set_rs(1, b);
      exp_q.push_back(model[a]); exp_q.push_back(model[b]);
      #1;
      exp = exp_q.pop_front(); got = rs_port(0); checks++;
      if (got !== exp) begin errors++; $display("FAIL rand_rs0 x%0d got=%h exp=%h", a, got, exp); end
      exp = exp_q.pop_front(); got = rs_port(1); checks++;
      if (got !== exp) begin errors++; $display("FAIL rand_rs1 x%0d got=%h exp=%h", b, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clear_drop();
    test_reset_midsweep();
    test_bypass();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
